// File: rtl/mem_dump.sv
// mem_dump: walks [start_addr..end_addr] of memory_unit through one read port and
//   streams each word out as a valid/ready beat (addr, data, last flag).
// Latency: first read strobe 1 cycle after start; word presented 1 cycle after
//   mem_ready returns high. Backpressure: one word held until dump_ready, no new
//   read is issued while a word is held (at most one read in flight).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             one-cycle pulse, accepted only when idle
//   start_addr/end_addr  inclusive range, sampled on an accepted start
//   mem_ready, read_data1       memory_unit status and read port 1
//   mem_execute, mem_func, address1  request strobe, function code, read address
//   dump_valid/dump_ready/dump_addr/dump_data/dump_last  output word stream
//   busy, finished    activity flag, end-of-dump pulse
//
// Optional: define MEM_DUMP_CHECKSUM_EN to add a `checksum` output holding the
//   modular sum of every accepted word of the current dump.
//
// ADDR_W/DATA_W default to the memory_unit widths used by the system build.

module mem_dump #(
  parameter int         ADDR_W    = 8,
  parameter int         DATA_W    = 64,
  parameter logic [1:0] READ_FUNC = 2'b00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data1,
  output logic              mem_execute,
  output logic [1:0]        mem_func,
  output logic [ADDR_W-1:0] address1,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
`ifdef MEM_DUMP_CHECKSUM_EN
  output logic [DATA_W-1:0] checksum,
`endif
  output logic              busy,
  output logic              finished
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_REQ     = 3'd1,
    S_WAIT_LO = 3'd2,
    S_WAIT_HI = 3'd3,
    S_HOLD    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              dump_valid_q, dump_valid_d;
  logic [ADDR_W-1:0] dump_addr_q, dump_addr_d;
  logic [DATA_W-1:0] dump_data_q, dump_data_d;
  logic              dump_last_q, dump_last_d;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cur_q        <= '0;
      last_q       <= '0;
      dump_valid_q <= 1'b0;
      dump_addr_q  <= '0;
      dump_data_q  <= '0;
      dump_last_q  <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      dump_valid_q <= dump_valid_d;
      dump_addr_q  <= dump_addr_d;
      dump_data_q  <= dump_data_d;
      dump_last_q  <= dump_last_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_d       = last_q;
    dump_valid_d = dump_valid_q;
    dump_addr_d  = dump_addr_q;
    dump_data_d  = dump_data_q;
    dump_last_d  = dump_last_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    mem_execute  = 1'b0;
    mem_func     = 2'b00;
    address1     = '0;
    busy         = 1'b0;
    finished     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cur_d   = start_addr;
          last_d  = end_addr;
`ifdef MEM_DUMP_CHECKSUM_EN
          checksum_d = '0;
`endif
          state_d = S_REQ;
        end
      end

      S_REQ: begin
        busy     = 1'b1;
        address1 = cur_q;
        if (mem_ready) begin
          mem_execute = 1'b1;
          mem_func    = READ_FUNC;
          state_d     = S_WAIT_LO;
        end
      end

      // The memory drops ready to acknowledge the request; only after that
      // does a high ready mean the read data is available.
      S_WAIT_LO: begin
        busy     = 1'b1;
        address1 = cur_q;
        if (!mem_ready) begin
          state_d = S_WAIT_HI;
        end
      end

      S_WAIT_HI: begin
        busy     = 1'b1;
        address1 = cur_q;
        if (mem_ready) begin
          dump_valid_d = 1'b1;
          dump_data_d  = read_data1;
          dump_addr_d  = cur_q;
          dump_last_d  = (cur_q == last_q);
          state_d      = S_HOLD;
        end
      end

      S_HOLD: begin
        busy = 1'b1;
        if (dump_ready) begin
          dump_valid_d = 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
          checksum_d = checksum_q + dump_data_q;
`endif
          if (dump_last_q) begin
            state_d = S_DONE;
          end else begin
            // Wraps through the top of the address space when start > end.
            cur_d   = cur_q + 1'b1;
            state_d = S_REQ;
          end
        end
      end

      S_DONE: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dump_valid = dump_valid_q;
  assign dump_addr  = dump_addr_q;
  assign dump_data  = dump_data_q;
  assign dump_last  = dump_last_q;
`ifdef MEM_DUMP_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_mem_dump.sv
// tb_mem_dump: directed bench for mem_dump with a behavioural memory_unit model
//   (configurable ready-low time per read) and a stream monitor.
// Covers reset, single word, backpressure, slow memory, wrap, ignored start,
//   abort by reset, and the checksum build option when enabled.

module tb_mem_dump;
  localparam int AW = 8;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] end_addr = '0;
  logic          mem_ready = 1'b1;
  logic [DW-1:0] read_data1 = '0;
  logic          mem_execute;
  logic [1:0]    mem_func;
  logic [AW-1:0] address1;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_last;
  logic          busy;
  logic          finished;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  always #5 clk = ~clk;

  mem_dump #(.ADDR_W(AW), .DATA_W(DW), .READ_FUNC(2'b00)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .mem_ready  (mem_ready),
    .read_data1 (read_data1),
    .mem_execute(mem_execute),
    .mem_func   (mem_func),
    .address1   (address1),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
`ifdef MEM_DUMP_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .busy       (busy),
    .finished   (finished)
  );

  // ---------------- memory_unit model ----------------
  logic [DW-1:0] mem [256];
  int            lat = 1;
  int            mcnt = 0;

  always @(posedge clk) begin
    if (mem_execute) begin
      mem_ready  <= 1'b0;
      mcnt       <= lat - 1;
      read_data1 <= mem[address1];
    end else if (!mem_ready) begin
      if (mcnt == 0) mem_ready <= 1'b1;
      else           mcnt <= mcnt - 1;
    end
  end

  // ---------------- sink ready: fixed or toggling every 3 cycles ----------------
  logic rdy_cmd = 1'b0;
  logic bp_en   = 1'b0;
  logic bp_q    = 1'b0;
  int   bp_cnt  = 0;

  always begin
    @(posedge clk);
    #1;
    if (bp_en) begin
      bp_cnt = bp_cnt + 1;
      if (bp_cnt == 3) begin
        bp_cnt = 0;
        bp_q   = ~bp_q;
      end
    end
  end

  assign dump_ready = bp_en ? bp_q : rdy_cmd;

  // ---------------- checking ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int            cyc = 0;
  int            n_exec, exec_hold_err, func_err, stab_err, lat_err;
  int            fin_cnt, last_beat_cyc, fin_lat, start_cyc, first_exec_cyc, rise_cyc;
  logic [AW-1:0] exec_addr0;
  logic [DW-1:0] fin_chk;
  logic [AW-1:0] b_addr [$];
  logic [DW-1:0] b_data [$];
  logic          b_last [$];
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0, pm = 1'b1;
  logic [AW-1:0] pa = '0;
  logic [DW-1:0] pd = '0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pv = 1'b0;
      pr = 1'b0;
      pm = 1'b1;
    end else begin
      if (mem_execute) begin
        if (n_exec == 0) begin
          first_exec_cyc = cyc;
          exec_addr0     = address1;
        end
        n_exec = n_exec + 1;
        if (dump_valid) exec_hold_err = exec_hold_err + 1;
      end
      if (!mem_execute && mem_func != 2'b00) func_err = func_err + 1;
      if (pv && !pr && (!dump_valid || dump_data != pd || dump_addr != pa || dump_last != pl))
        stab_err = stab_err + 1;
      if (mem_ready && !pm) rise_cyc = cyc;
      if (dump_valid && !pv && (cyc - rise_cyc) != 1) lat_err = lat_err + 1;
      if (dump_valid && dump_ready) begin
        b_addr.push_back(dump_addr);
        b_data.push_back(dump_data);
        b_last.push_back(dump_last);
        last_beat_cyc = cyc;
      end
      if (finished) begin
        fin_cnt = fin_cnt + 1;
        fin_lat = cyc - last_beat_cyc;
`ifdef MEM_DUMP_CHECKSUM_EN
        fin_chk = checksum;
`else
        fin_chk = '0;
`endif
      end
      pv = dump_valid;
      pr = dump_ready;
      pa = dump_addr;
      pd = dump_data;
      pl = dump_last;
      pm = mem_ready;
    end
  end

  task automatic clear_stats();
    n_exec = 0; exec_hold_err = 0; func_err = 0; stab_err = 0; lat_err = 0;
    fin_cnt = 0; last_beat_cyc = 0; fin_lat = 0; first_exec_cyc = 0;
    exec_addr0 = '0; fin_chk = '0;
    b_addr.delete(); b_data.delete(); b_last.delete();
  endtask

  task automatic pulse_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    @(posedge clk);
    #1;
    start      = 1'b1;
    start_addr = sa;
    end_addr   = ea;
    start_cyc  = cyc + 1;   // the falling edge at which start is seen high
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_fin(input string tag);
    int n = 0;
    while (fin_cnt == 0 && n < 3000) begin
      @(posedge clk);
      n = n + 1;
    end
    if (fin_cnt == 0) check({tag, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input string tag, input int n,
                             input logic [AW-1:0] ea [4], input logic [DW-1:0] ed [4]);
    check({tag, "_count"}, 64'(b_addr.size()), 64'(n));
    if (b_addr.size() == n) begin
      for (int i = 0; i < n; i++) begin
        check($sformatf("%s_addr%0d", tag, i), 64'(b_addr[i]), 64'(ea[i]));
        check($sformatf("%s_data%0d", tag, i), b_data[i], ed[i]);
        check($sformatf("%s_last%0d", tag, i), 64'(b_last[i]), 64'(i == n - 1));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  logic [AW-1:0] ea [4];
  logic [DW-1:0] ed [4];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 64'hDEAD_0000_0000_0000 | 64'(i);
    clear_stats();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {59'd0, dump_valid, busy, mem_execute, finished, dump_last}, 64'd0);
    check("rst_addr", {48'd0, address1, dump_addr}, 64'd0);
    check("rst_data", dump_data, 64'd0);
    rst = 1'b0;

    // Single word
    mem[5] = 64'h0000_0000_0000_0123;
    rdy_cmd = 1'b1;
    clear_stats();
    pulse_start(8'd5, 8'd5);
    wait_fin("single");
    ea = '{8'd5, 8'd0, 8'd0, 8'd0};
    ed = '{64'h123, 64'd0, 64'd0, 64'd0};
    check_beats("single", 1, ea, ed);
    check("single_fin_lat", 64'(fin_lat), 64'd1);
    check("single_nexec", 64'(n_exec), 64'd1);
    check("single_exec_addr", 64'(exec_addr0), 64'd5);
    check("single_start_lat", 64'(first_exec_cyc - start_cyc), 64'd1);
    check("single_busy_after", 64'(busy), 64'd0);

    // Range with backpressure
    mem[1] = 64'hA; mem[2] = 64'hB; mem[3] = 64'hC; mem[4] = 64'hD;
    clear_stats();
    bp_cnt = 0; bp_q = 1'b0; bp_en = 1'b1;
    pulse_start(8'd1, 8'd4);
    wait_fin("bp");
    bp_en = 1'b0;
    ea = '{8'd1, 8'd2, 8'd3, 8'd4};
    ed = '{64'hA, 64'hB, 64'hC, 64'hD};
    check_beats("bp", 4, ea, ed);
    check("bp_stable", 64'(stab_err), 64'd0);
    check("bp_exec_hold", 64'(exec_hold_err), 64'd0);
    check("bp_nexec", 64'(n_exec), 64'd4);
    check("bp_func", 64'(func_err), 64'd0);

    // Slow memory: ready low for 7 cycles per read
    mem[40] = 64'h111; mem[41] = 64'h222; mem[42] = 64'h333;
    lat = 7;
    clear_stats();
    pulse_start(8'd40, 8'd42);
    wait_fin("slow");
    lat = 1;
    ea = '{8'd40, 8'd41, 8'd42, 8'd0};
    ed = '{64'h111, 64'h222, 64'h333, 64'd0};
    check_beats("slow", 3, ea, ed);
    check("slow_valid_lat", 64'(lat_err), 64'd0);
    check("slow_nexec", 64'(n_exec), 64'd3);

    // Wrap through the top of the address space
    mem[254] = 64'hFE01; mem[255] = 64'hFF02; mem[0] = 64'h0003; mem[1] = 64'h0104;
    clear_stats();
    pulse_start(8'd254, 8'd1);
    wait_fin("wrap");
    ea = '{8'd254, 8'd255, 8'd0, 8'd1};
    ed = '{64'hFE01, 64'hFF02, 64'h0003, 64'h0104};
    check_beats("wrap", 4, ea, ed);

    // Start while busy is ignored
    mem[20] = 64'h2020; mem[21] = 64'h2121; mem[22] = 64'h2222; mem[100] = 64'h1001;
    clear_stats();
    pulse_start(8'd20, 8'd22);
    repeat (2) @(posedge clk);
    pulse_start(8'd100, 8'd100);
    wait_fin("ign");
    repeat (10) @(posedge clk);
    #1;
    ea = '{8'd20, 8'd21, 8'd22, 8'd0};
    ed = '{64'h2020, 64'h2121, 64'h2222, 64'd0};
    check_beats("ign", 3, ea, ed);
    check("ign_fin_cnt", 64'(fin_cnt), 64'd1);
    check("ign_busy", 64'(busy), 64'd0);

    // Reset while holding a word
    rdy_cmd = 1'b0;
    clear_stats();
    pulse_start(8'd3, 8'd6);
    begin
      int n = 0;
      while (!dump_valid && n < 100) begin
        @(posedge clk);
        #1;
        n = n + 1;
      end
    end
    check("abort_hold_reached", 64'(dump_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("abort_ctrl", {59'd0, dump_valid, busy, mem_execute, finished, dump_last}, 64'd0);
    check("abort_addr", {48'd0, address1, dump_addr}, 64'd0);
    check("abort_data", dump_data, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_cmd = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_fin", 64'(fin_cnt), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    clear_stats();
    pulse_start(8'd3, 8'd4);
    wait_fin("fresh");
    ea = '{8'd3, 8'd4, 8'd0, 8'd0};
    ed = '{64'hC, 64'hD, 64'd0, 64'd0};
    check_beats("fresh", 2, ea, ed);

`ifdef MEM_DUMP_CHECKSUM_EN
    // Checksum over 0x10 + 0x20 + 0xFF
    mem[8] = 64'h10; mem[9] = 64'h20; mem[10] = 64'hFF;
    clear_stats();
    pulse_start(8'd8, 8'd10);
    wait_fin("csum");
    check("csum_final", fin_chk, 64'h12F);
    check("csum_hold", checksum, 64'h12F);
    rdy_cmd = 1'b0;
    clear_stats();
    pulse_start(8'd8, 8'd8);
    check("csum_cleared", checksum, 64'd0);
    rdy_cmd = 1'b1;
    wait_fin("csum2");
    check("csum_single", fin_chk, 64'h10);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_dump.md
Name: mem_dump

Overview:
- Memory readback engine. After traversal finishes, it walks a contiguous address range of memory_unit and streams every word out over a valid/ready interface, for bench checking and later host readout.
- It is the reader counterpart to the hex-file image load.
- It sits as an additional memory-port master behind memory_mux, on its own select code, and issues only read requests.

Parameters:
- ADDR_W, `memory_addr_width: address width.
- DATA_W, `memory_data_width: word width.
- READ_FUNC, 2'b00: mem_func encoding for a single-word read on address1/read_data1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse; begins a dump. Ignored unless idle.
- start_addr  input  ADDR_W  first address, inclusive. Sampled on start.
- end_addr  input  ADDR_W  last address, inclusive. Sampled on start.
- mem_ready  input  1  memory_unit is_ready.
- read_data1  input  DATA_W  memory_unit read port 1.
- mem_execute  output  1  one-cycle request strobe.
- mem_func  output  2  READ_FUNC while requesting, else 0.
- address1  output  ADDR_W  read address.
- dump_valid  output  1  a word is presented.
- dump_ready  input  1  sink accepts the word.
- dump_addr  output  ADDR_W  address of the presented word.
- dump_data  output  DATA_W  presented word.
- dump_last  output  1  presented word is at end_addr.
- busy  output  1  high from the cycle after start until finished.
- finished  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Internal address counter and end register cleared. Reset mid-dump abandons the transfer, with no finished pulse.
- States:
  - IDLE: on start, latch cur=start_addr and last=end_addr, go to REQ.
  - REQ:
    - Wait for mem_ready=1.
    - In that cycle assert mem_execute=1, mem_func=READ_FUNC, address1=cur for exactly one cycle, then go to WAIT_LO.
  - WAIT_LO: wait for mem_ready=0, which acknowledges the request. Go to WAIT_HI.
  - WAIT_HI: on the first cycle with mem_ready=1, register read_data1 into dump_data, register cur into dump_addr, set dump_valid=1, set dump_last=(cur==last). Go to HOLD.
  - HOLD:
    - dump_valid, dump_data, dump_addr and dump_last stay stable until dump_valid&&dump_ready.
    - On that handshake, clear dump_valid.
    - If dump_last: go to DONE.
    - Else: cur=cur+1 (mod 2^ADDR_W) and go to REQ.
  - DONE: pulse finished=1 for one cycle, clear busy, return to IDLE.
- address1 holds cur from REQ through WAIT_HI; it is 0 in IDLE.
- Latency:
  - First request strobe comes 1 cycle after start, given mem_ready=1.
  - Data is valid 1 cycle after mem_ready returns high.
  - At most one outstanding read. No read is issued while a word is held.
- dump_ready may be high before dump_valid; it has no effect outside HOLD.
- start while busy is ignored, and the latched range is unchanged.
- start_addr==end_addr: exactly one word is dumped, with dump_last set.
- start_addr>end_addr: the counter wraps through 2^ADDR_W-1 to 0 and continues to end_addr. The total word count is (end_addr-start_addr+1) mod 2^ADDR_W, where a result of 0 means 2^ADDR_W words.
- start and rst asserted in the same cycle: reset wins.
- The module never drives a write; mem_func is 0 whenever mem_execute=0.

Optional Feature:
- Macro: MEM_DUMP_CHECKSUM_EN.
- With the macro defined:
  - Extra output checksum [DATA_W-1:0], reset to 0, cleared on an accepted start.
  - On each dump handshake: checksum <= checksum + dump_data (mod 2^DATA_W).
  - The value is final and stable in the cycle finished pulses, and holds until the next start.
- Without the macro: no checksum port and no adder. The rest of the behaviour is identical.

Test Plan:
- Single word: mem[5]=0x0000_0000_0000_0123 (DATA_W bits), start_addr=end_addr=5, dump_ready=1 → one beat with dump_addr=5, dump_data=0x123, dump_last=1; finished 1 cycle after the beat; exactly one mem_execute pulse, with address1=5.
- Range with backpressure: mem[1..4]=0xA,0xB,0xC,0xD, dump_ready toggled every 3 cycles → beats A,B,C,D in order; data stable while stalled; only the D beat has dump_last; no mem_execute while dump_valid=1.
- Slow memory: model holds mem_ready=0 for 7 cycles per read → dump_valid rises exactly 1 cycle after mem_ready returns high; the strobe is never reissued.
- Wrap: start_addr=2^ADDR_W-2, end_addr=1 → 4 beats with addresses 2^ADDR_W-2, 2^ADDR_W-1, 0, 1; dump_last only on 1.
- Abort and ignore: start during a dump is ignored (range unchanged); rst asserted while in HOLD → all outputs 0 asynchronously, no finished pulse; a fresh start afterwards dumps correctly.
- MEM_DUMP_CHECKSUM_EN defined, words 0x10, 0x20, 0xFF over addresses 8..10 → checksum=0x12F at the finished pulse; 0 after the next start.
